// File: rtl/vga_timing_gen_if.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_if
//
// Bundles the raster timing generator's configuration inputs and its timing
// outputs so they travel between blocks as one port.
//
// Configuration (driven by the APB configuration block):
//   enable_i       run the raster; low holds the generator idle
//   hsync_end_i    [10:0] last horizontal count (line length - 1)
//   hpulse_end_i   [7:0]  last count of the hsync pulse
//   hdata_begin_i  [7:0]  first active column count
//   hdata_end_i    [9:0]  first column count after active video
//   vsync_end_i    [8:0]  last line count (frame lines - 1)
//   vpulse_end_i   [2:0]  last line count of the vsync pulse
//   vdata_begin_i  [4:0]  first active line count
//   vdata_end_i    [8:0]  first line count after active video
//
// Timing outputs (consumed by pixel fetch / output stages):
//   hsync_o, vsync_o    active-low syncs
//   de_o                active-video data enable
//   x_o [9:0], y_o [8:0] active pixel coordinates (0 outside active video)
//   frame_start_o       one-cycle pulse at raster position (0,0)
//   cfg_err_o           sticky inconsistent-configuration flag
//
// Modports:
//   master  the timing generator itself
//   slave   the surrounding logic that configures it and uses its outputs
// ---------------------------------------------------------------------------
interface vga_timing_gen_if;

  logic        enable_i;
  logic [10:0] hsync_end_i;
  logic [7:0]  hpulse_end_i;
  logic [7:0]  hdata_begin_i;
  logic [9:0]  hdata_end_i;
  logic [8:0]  vsync_end_i;
  logic [2:0]  vpulse_end_i;
  logic [4:0]  vdata_begin_i;
  logic [8:0]  vdata_end_i;

  logic        hsync_o;
  logic        vsync_o;
  logic        de_o;
  logic [9:0]  x_o;
  logic [8:0]  y_o;
  logic        frame_start_o;
  logic        cfg_err_o;

  modport master (
    input  enable_i,
    input  hsync_end_i,
    input  hpulse_end_i,
    input  hdata_begin_i,
    input  hdata_end_i,
    input  vsync_end_i,
    input  vpulse_end_i,
    input  vdata_begin_i,
    input  vdata_end_i,
    output hsync_o,
    output vsync_o,
    output de_o,
    output x_o,
    output y_o,
    output frame_start_o,
    output cfg_err_o
  );

  modport slave (
    output enable_i,
    output hsync_end_i,
    output hpulse_end_i,
    output hdata_begin_i,
    output hdata_end_i,
    output vsync_end_i,
    output vpulse_end_i,
    output vdata_begin_i,
    output vdata_end_i,
    input  hsync_o,
    input  vsync_o,
    input  de_o,
    input  x_o,
    input  y_o,
    input  frame_start_o,
    input  cfg_err_o
  );

endinterface

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Raster timing generator for the VGA pipeline. A horizontal counter runs
// 0..hsync_end and a vertical counter advances once per line, 0..vsync_end.
// Sync pulses, data enable, active coordinates and a frame-start strobe are
// decoded from the counters and registered, so every output lags the counter
// state by exactly one clock.
//
// All eight timing fields are copied into shadow registers that only update
// while the raster is disabled or on the last pixel of a frame, so a
// reconfiguration from the bus can never tear a frame in progress.
//
// Ports:
//   clk     pixel clock
//   resetn  asynchronous active-low reset
//   bus     vga_timing_gen_if.master: configuration in, timing out
// ---------------------------------------------------------------------------
module vga_timing_gen (
  input  logic             clk,
  input  logic             resetn,
  vga_timing_gen_if.master bus
);

  typedef struct packed {
    logic [10:0] hsync_end;
    logic [7:0]  hpulse_end;
    logic [7:0]  hdata_begin;
    logic [9:0]  hdata_end;
    logic [8:0]  vsync_end;
    logic [2:0]  vpulse_end;
    logic [4:0]  vdata_begin;
    logic [8:0]  vdata_end;
  } timing_cfg_t;

  timing_cfg_t cfg_in;
  timing_cfg_t shadow;

  logic [10:0] hcnt;
  logic [8:0]  vcnt;

  logic        line_end;
  logic        frame_end;
  logic        shadow_load;
  logic        cfg_bad;

  logic [11:0] h_limit;
  logic [9:0]  v_limit;

  logic [10:0] hpulse_end_x;
  logic [10:0] hdata_begin_x;
  logic [10:0] hdata_end_x;
  logic [8:0]  vpulse_end_x;
  logic [8:0]  vdata_begin_x;
  logic [8:0]  vdata_end_x;

  logic        h_active;
  logic        v_active;
  logic        hs_n;
  logic        vs_n;
  logic        de;
  logic        fs;
  logic [9:0]  x;
  logic [8:0]  y;

  logic        hsync_q;
  logic        vsync_q;
  logic        de_q;
  logic [9:0]  x_q;
  logic [8:0]  y_q;
  logic        fs_q;
  logic        cfg_err_q;

  // Gather the live configuration fields into one word so the shadow copy
  // is a single register load.
  always_comb begin
    cfg_in             = '0;
    cfg_in.hsync_end   = bus.hsync_end_i;
    cfg_in.hpulse_end  = bus.hpulse_end_i;
    cfg_in.hdata_begin = bus.hdata_begin_i;
    cfg_in.hdata_end   = bus.hdata_end_i;
    cfg_in.vsync_end   = bus.vsync_end_i;
    cfg_in.vpulse_end  = bus.vpulse_end_i;
    cfg_in.vdata_begin = bus.vdata_begin_i;
    cfg_in.vdata_end   = bus.vdata_end_i;
  end

  // End-of-line and end-of-frame are judged against the shadow copy, the
  // geometry of the frame currently on screen. Shadows follow the inputs
  // freely while idle, and only at the frame wrap while running.
  always_comb begin
    line_end    = (hcnt == shadow.hsync_end);
    frame_end   = line_end && (vcnt == shadow.vsync_end);
    shadow_load = !bus.enable_i || frame_end;
  end

  // Consistency check of the configuration about to be latched. Limits are
  // computed one bit wider so hsync_end+1 / vsync_end+1 cannot overflow.
  always_comb begin
    h_limit = {1'b0, cfg_in.hsync_end} + 12'd1;
    v_limit = {1'b0, cfg_in.vsync_end} + 10'd1;
    cfg_bad = (cfg_in.hpulse_end >= cfg_in.hdata_begin)
           || ({2'b00, cfg_in.hdata_begin} > cfg_in.hdata_end)
           || ({2'b00, cfg_in.hdata_end} > h_limit)
           || ({2'b00, cfg_in.vpulse_end} >= cfg_in.vdata_begin)
           || ({4'b0000, cfg_in.vdata_begin} > cfg_in.vdata_end)
           || ({1'b0, cfg_in.vdata_end} > v_limit);
  end

  // Shadow timing registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shadow <= '0;
    end else if (shadow_load) begin
      shadow <= cfg_in;
    end
  end

  // Raster counters. Because the shadows only change on the wrap edge, when
  // both counters also return to 0, hcnt can never overshoot hsync_end.
  // A zero-length line or frame simply wraps every cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (!bus.enable_i) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (line_end) begin
      hcnt <= '0;
      if (vcnt == shadow.vsync_end) begin
        vcnt <= '0;
      end else begin
        vcnt <= vcnt + 9'd1;
      end
    end else begin
      hcnt <= hcnt + 11'd1;
    end
  end

  // Decode of the current raster position against the shadow geometry.
  // Coordinates are a plain modular subtraction; erroneous configurations
  // are rasterised as decoded, without clamping.
  always_comb begin
    hpulse_end_x  = {3'b000, shadow.hpulse_end};
    hdata_begin_x = {3'b000, shadow.hdata_begin};
    hdata_end_x   = {1'b0, shadow.hdata_end};
    vpulse_end_x  = {6'b000000, shadow.vpulse_end};
    vdata_begin_x = {4'b0000, shadow.vdata_begin};
    vdata_end_x   = shadow.vdata_end;

    hs_n     = !(hcnt <= hpulse_end_x);
    vs_n     = !(vcnt <= vpulse_end_x);
    h_active = (hcnt >= hdata_begin_x) && (hcnt < hdata_end_x);
    v_active = (vcnt >= vdata_begin_x) && (vcnt < vdata_end_x);
    de       = bus.enable_i && h_active && v_active;
    fs       = bus.enable_i && (hcnt == 11'd0) && (vcnt == 9'd0);
    x        = hcnt[9:0] - hdata_begin_x[9:0];
    y        = vcnt - vdata_begin_x;
  end

  // Output registers. Disabling forces the idle pattern on the same edge
  // that clears the counters, so nothing from a partial frame leaks out.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      de_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      fs_q    <= 1'b0;
    end else if (!bus.enable_i) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      de_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      fs_q    <= 1'b0;
    end else begin
      hsync_q <= hs_n;
      vsync_q <= vs_n;
      de_q    <= de;
      x_q     <= de ? x : 10'd0;
      y_q     <= de ? y : 9'd0;
      fs_q    <= fs;
    end
  end

  // Sticky configuration error: only configurations latched at a running
  // frame wrap are judged, and only reset clears the flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cfg_err_q <= 1'b0;
    end else if (bus.enable_i && frame_end && cfg_bad) begin
      cfg_err_q <= 1'b1;
    end
  end

  assign bus.hsync_o       = hsync_q;
  assign bus.vsync_o       = vsync_q;
  assign bus.de_o          = de_q;
  assign bus.x_o           = x_q;
  assign bus.y_o           = y_q;
  assign bus.frame_start_o = fs_q;
  assign bus.cfg_err_o     = cfg_err_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Bench for vga_timing_gen. A frame-position model (one counter modulo the
// frame length, split into line/column by division) predicts every output
// each cycle; directed steps cover the reference raster, mid-frame
// reconfiguration, disable/enable, async reset, the sticky config error and
// degenerate sizes, followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  typedef struct {
    int hse;
    int hpe;
    int hdb;
    int hde;
    int vse;
    int vpe;
    int vdb;
    int vde;
  } cfg_t;

  logic clk;
  logic resetn;

  vga_timing_gen_if bus ();

  vga_timing_gen dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int total;
  int bad;

  // Currently applied stimulus.
  bit   cur_en;
  cfg_t cur_cfg;

  // Model state.
  cfg_t m_sh;
  int   m_pos;
  int   e_hs, e_vs, e_de, e_x, e_y, e_fs, e_err;

  cfg_t small_cfg;
  cfg_t alt_cfg;
  cfg_t zero_cfg;

  int n;
  int hs_low, vs_low, vs_first, de_cnt, fs_cnt;

  // Free-running pixel clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit cfg_is_bad(input cfg_t c);
    return (c.hpe >= c.hdb) || (c.hdb > c.hde) || (c.hde > c.hse + 1)
        || (c.vpe >= c.vdb) || (c.vdb > c.vde) || (c.vde > c.vse + 1);
  endfunction

  function automatic cfg_t rand_cfg();
    cfg_t c;
    c.hse = $urandom_range(0, 15);
    c.hpe = $urandom_range(0, 7);
    c.hdb = $urandom_range(0, 10);
    c.hde = $urandom_range(0, 20);
    c.vse = $urandom_range(0, 7);
    c.vpe = $urandom_range(0, 3);
    c.vdb = $urandom_range(0, 6);
    c.vde = $urandom_range(0, 9);
    return c;
  endfunction

  task automatic apply_stimulus(input bit en, input cfg_t c);
    cur_en            = en;
    cur_cfg           = c;
    bus.enable_i      = en;
    bus.hsync_end_i   = 11'(c.hse);
    bus.hpulse_end_i  = 8'(c.hpe);
    bus.hdata_begin_i = 8'(c.hdb);
    bus.hdata_end_i   = 10'(c.hde);
    bus.vsync_end_i   = 9'(c.vse);
    bus.vpulse_end_i  = 3'(c.vpe);
    bus.vdata_begin_i = 5'(c.vdb);
    bus.vdata_end_i   = 9'(c.vde);
  endtask

  task automatic model_reset();
    m_sh  = zero_cfg;
    m_pos = 0;
    e_hs  = 1;
    e_vs  = 1;
    e_de  = 0;
    e_x   = 0;
    e_y   = 0;
    e_fs  = 0;
    e_err = 0;
  endtask

  // One clock edge of the model: position within the frame is a single
  // counter; column and line come from division by the line length.
  task automatic model_edge();
    int  line_len;
    int  frame_len;
    int  h;
    int  v;
    bit  wrap;
    line_len  = m_sh.hse + 1;
    frame_len = line_len * (m_sh.vse + 1);
    h         = m_pos % line_len;
    v         = m_pos / line_len;
    wrap      = (m_pos == frame_len - 1);
    if (!cur_en) begin
      e_hs = 1; e_vs = 1; e_de = 0; e_x = 0; e_y = 0; e_fs = 0;
    end else begin
      e_hs = (h <= m_sh.hpe) ? 0 : 1;
      e_vs = (v <= m_sh.vpe) ? 0 : 1;
      e_de = (h >= m_sh.hdb && h < m_sh.hde && v >= m_sh.vdb && v < m_sh.vde) ? 1 : 0;
      e_x  = e_de ? ((h - m_sh.hdb) & 1023) : 0;
      e_y  = e_de ? ((v - m_sh.vdb) & 511) : 0;
      e_fs = (m_pos == 0) ? 1 : 0;
    end
    if (cur_en && wrap && cfg_is_bad(cur_cfg)) e_err = 1;
    if (!cur_en || wrap) m_sh = cur_cfg;
    m_pos = cur_en ? (m_pos + 1) % frame_len : 0;
  endtask

  task automatic check_all();
    check_output("hsync", 32'(bus.hsync_o), 32'(e_hs));
    check_output("vsync", 32'(bus.vsync_o), 32'(e_vs));
    check_output("de", 32'(bus.de_o), 32'(e_de));
    check_output("x", 32'(bus.x_o), 32'(e_x));
    check_output("y", 32'(bus.y_o), 32'(e_y));
    check_output("frame_start", 32'(bus.frame_start_o), 32'(e_fs));
    check_output("cfg_err", 32'(bus.cfg_err_o), 32'(e_err));
  endtask

  // Advance one clock; outputs are compared 1 time unit after the edge.
  task automatic step_cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic wait_fs(input int limit);
    int k;
    k = 0;
    while (!bus.frame_start_o && k < limit) begin
      step_cycle();
      k++;
    end
    check_output("wait_fs", 32'(bus.frame_start_o), 32'd1);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    zero_cfg  = '{0, 0, 0, 0, 0, 0, 0, 0};
    small_cfg = '{9, 1, 3, 7, 5, 0, 2, 4};
    resetn = 1'b1;
    apply_stimulus(1'b0, zero_cfg);

    // Reset state.
    #2 resetn = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;

    // Small raster: load while idle, then run.
    $display("[TB] small raster");
    apply_stimulus(1'b0, small_cfg);
    step_cycle();
    apply_stimulus(1'b1, small_cfg);
    wait_fs(200);
    hs_low = 0; vs_low = 0; vs_first = 0; de_cnt = 0; fs_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (!bus.hsync_o) hs_low++;
      if (!bus.vsync_o) vs_low++;
      if (!bus.vsync_o && i < 10) vs_first++;
      if (bus.frame_start_o) fs_cnt++;
      if (bus.de_o) begin
        if (de_cnt < 8) begin
          check_output("raster_x_seq", 32'(bus.x_o), 32'(de_cnt % 4));
          check_output("raster_y_seq", 32'(bus.y_o), 32'(de_cnt / 4));
        end
        de_cnt++;
      end
      step_cycle();
    end
    check_output("hsync_low_count", 32'(hs_low), 32'd12);
    check_output("vsync_low_count", 32'(vs_low), 32'd10);
    check_output("vsync_low_first10", 32'(vs_first), 32'd10);
    check_output("de_count", 32'(de_cnt), 32'd8);
    check_output("fs_per_frame", 32'(fs_cnt), 32'd1);
    check_output("fs_period_60", 32'(bus.frame_start_o), 32'd1);

    // Mid-frame reconfiguration: current frame keeps its geometry.
    $display("[TB] mid-frame reconfiguration");
    alt_cfg     = small_cfg;
    alt_cfg.hse = 19;
    n = 0;
    repeat (25) begin
      step_cycle();
      n++;
    end
    apply_stimulus(1'b1, alt_cfg);
    do begin
      step_cycle();
      n++;
    end while (!bus.frame_start_o && n < 400);
    check_output("reconf_current_frame", 32'(n), 32'd60);
    n = 0;
    do begin
      step_cycle();
      n++;
    end while (!bus.frame_start_o && n < 400);
    check_output("reconf_next_frame", 32'(n), 32'd120);
    apply_stimulus(1'b1, small_cfg);
    n = 0;
    do begin
      step_cycle();
      n++;
    end while (!bus.frame_start_o && n < 400);
    check_output("reconf_restore_frame", 32'(n), 32'd120);

    // Disable at cycle 33 of a frame, then re-enable.
    $display("[TB] disable/enable");
    repeat (33) step_cycle();
    apply_stimulus(1'b0, small_cfg);
    step_cycle();
    check_output("disable_de", 32'(bus.de_o), 32'd0);
    check_output("disable_hsync", 32'(bus.hsync_o), 32'd1);
    check_output("disable_vsync", 32'(bus.vsync_o), 32'd1);
    repeat (10) step_cycle();
    check_output("idle_hsync", 32'(bus.hsync_o), 32'd1);
    check_output("idle_fs", 32'(bus.frame_start_o), 32'd0);
    apply_stimulus(1'b1, small_cfg);
    check_output("enable_edge_fs", 32'(bus.frame_start_o), 32'd0);
    step_cycle();
    check_output("reenable_fs", 32'(bus.frame_start_o), 32'd1);

    // Asynchronous reset while de_o is high.
    $display("[TB] async reset mid-line");
    n = 0;
    while (!bus.de_o && n < 200) begin
      step_cycle();
      n++;
    end
    check_output("found_de", 32'(bus.de_o), 32'd1);
    #2 resetn = 1'b0;
    model_reset();
    #1;
    check_output("areset_de", 32'(bus.de_o), 32'd0);
    check_output("areset_hsync", 32'(bus.hsync_o), 32'd1);
    check_output("areset_x", 32'(bus.x_o), 32'd0);
    check_output("areset_cfg_err", 32'(bus.cfg_err_o), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    step_cycle();
    check_output("post_reset_fs", 32'(bus.frame_start_o), 32'd1);
    repeat (70) step_cycle();

    // Sticky configuration error.
    $display("[TB] config error");
    alt_cfg     = small_cfg;
    alt_cfg.hdb = 8;
    alt_cfg.hde = 5;
    apply_stimulus(1'b1, alt_cfg);
    check_output("err_before_wrap", 32'(bus.cfg_err_o), 32'd0);
    n = 0;
    while (!bus.cfg_err_o && n < 200) begin
      step_cycle();
      n++;
    end
    check_output("err_after_wrap", 32'(bus.cfg_err_o), 32'd1);
    apply_stimulus(1'b1, small_cfg);
    repeat (130) step_cycle();
    check_output("err_sticky", 32'(bus.cfg_err_o), 32'd1);
    do_reset();
    #1;
    check_output("err_cleared", 32'(bus.cfg_err_o), 32'd0);

    // Degenerate 1x1 raster.
    $display("[TB] degenerate sizes");
    apply_stimulus(1'b0, zero_cfg);
    step_cycle();
    apply_stimulus(1'b1, zero_cfg);
    for (int i = 0; i < 20; i++) begin
      step_cycle();
      check_output("degen_fs", 32'(bus.frame_start_o), 32'd1);
      check_output("degen_de", 32'(bus.de_o), 32'd0);
    end

    // Randomized run: enable toggles, config changes, occasional resets.
    $display("[TB] random run");
    do_reset();
    apply_stimulus(1'b0, rand_cfg());
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 999);
      if (r < 15) begin
        apply_stimulus(!cur_en, cur_cfg);
      end else if (r < 50) begin
        apply_stimulus(cur_en, rand_cfg());
      end else if (r < 53) begin
        do_reset();
      end else if (r < 80 && !cur_en) begin
        apply_stimulus(1'b1, cur_cfg);
      end
      step_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
